// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm scheduler for the 24-hour timekeeper
//
// Holds an alarm time, compares it with the running time and sequences
// disarmed / armed / ringing / snooze, driving a 1 s on / 1 s off buzzer.
//
// Ports:
//   i_clock_24        system clock, all logic on posedge
//   i_reset           synchronous active-high reset
//   i_tick_1hz        one-cycle pulse per second from the timekeeper
//   i_hours/minutes/seconds   current time (0-23 / 0-59 / 0-59)
//   i_set_hour_inc    pulse: alarm hour +1 (wraps 23->0)
//   i_set_minute_inc  pulse: alarm minute +1 (wraps 59->0, no carry)
//   i_arm_toggle      pulse: toggle armed/disarmed
//   i_snooze          pulse: snooze a ringing alarm
//   i_dismiss         pulse: stop ringing/snooze, stay armed
//   o_alarm_hours/minutes     stored alarm time
//   o_armed           1 in every state except disarmed
//   o_ringing         1 only while ringing
//   o_snooze_active   1 only while snoozing
//   o_buzzer          buzzer enable
module alarm_controller #(
  parameter int SNOOZE_SECS       = 300,
  parameter int RING_TIMEOUT_SECS = 600
) (
  input  logic       i_clock_24,
  input  logic       i_reset,
  input  logic       i_tick_1hz,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  input  logic       i_set_hour_inc,
  input  logic       i_set_minute_inc,
  input  logic       i_arm_toggle,
  input  logic       i_snooze,
  input  logic       i_dismiss,
  output logic [4:0] o_alarm_hours,
  output logic [5:0] o_alarm_minutes,
  output logic       o_armed,
  output logic       o_ringing,
  output logic       o_snooze_active,
  output logic       o_buzzer
);

  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_SECS);
  localparam logic [11:0] RING_LAST   = 12'(RING_TIMEOUT_SECS - 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_alarm_hours;
  logic [5:0]  r_alarm_minutes;
  logic [11:0] r_ring_cnt;
  logic [11:0] r_snooze_cnt;
  logic        r_match_prev;
  logic        r_armed;
  logic        r_ringing;
  logic        r_snooze_active;
  logic        r_buzzer;

  state_t      w_next_state;
  logic [4:0]  w_next_alarm_hours;
  logic [5:0]  w_next_alarm_minutes;
  logic [11:0] w_next_ring_cnt;
  logic [11:0] w_next_snooze_cnt;
  logic        w_next_match_prev;
  logic        w_match;
  logic        w_trigger;
  logic        w_edit_ok;

  always_comb begin
    w_next_state         = r_state;
    w_next_alarm_hours   = r_alarm_hours;
    w_next_alarm_minutes = r_alarm_minutes;
    w_next_ring_cnt      = r_ring_cnt;
    w_next_snooze_cnt    = r_snooze_cnt;

    w_match   = (i_hours == r_alarm_hours) && (i_minutes == r_alarm_minutes) &&
                (i_seconds == 6'd0);
    w_trigger = w_match && !r_match_prev;
    w_edit_ok = (r_state == ST_DISARMED) || (r_state == ST_ARMED);

    if (w_edit_ok && i_set_hour_inc) begin
      w_next_alarm_hours = (r_alarm_hours == 5'd23) ? 5'd0 : r_alarm_hours + 5'd1;
    end
    if (w_edit_ok && i_set_minute_inc) begin
      w_next_alarm_minutes = (r_alarm_minutes == 6'd59) ? 6'd0 : r_alarm_minutes + 6'd1;
    end

    // An accepted edit pretends the match was already true, so moving the
    // alarm onto the current time cannot fire it.
    w_next_match_prev = (w_edit_ok && (i_set_hour_inc || i_set_minute_inc)) ? 1'b1 : w_match;

    case (r_state)
      ST_DISARMED: begin
        if (i_arm_toggle) w_next_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (i_arm_toggle) begin
          w_next_state = ST_DISARMED;
        end else if (w_trigger) begin
          w_next_state    = ST_RINGING;
          w_next_ring_cnt = 12'd0;
        end
      end
      ST_RINGING: begin
        if (i_arm_toggle) begin
          w_next_state = ST_DISARMED;
        end else if (i_dismiss) begin
          w_next_state = ST_ARMED;
        end else if (i_snooze) begin
          w_next_state      = ST_SNOOZE;
          w_next_snooze_cnt = SNOOZE_LOAD;
        end else if (i_tick_1hz) begin
          if (r_ring_cnt == RING_LAST) w_next_state = ST_ARMED;
          else w_next_ring_cnt = r_ring_cnt + 12'd1;
        end
      end
      ST_SNOOZE: begin
        if (i_arm_toggle) begin
          w_next_state = ST_DISARMED;
        end else if (i_dismiss) begin
          w_next_state = ST_ARMED;
        end else if (i_tick_1hz) begin
          if (r_snooze_cnt == 12'd1) begin
            w_next_state    = ST_RINGING;
            w_next_ring_cnt = 12'd0;
          end else begin
            w_next_snooze_cnt = r_snooze_cnt - 12'd1;
          end
        end
      end
      default: w_next_state = ST_DISARMED;
    endcase
  end

  always_ff @(posedge i_clock_24) begin
    if (i_reset) begin
      r_state         <= ST_DISARMED;
      r_alarm_hours   <= 5'd0;
      r_alarm_minutes <= 6'd0;
      r_ring_cnt      <= 12'd0;
      r_snooze_cnt    <= 12'd0;
      r_match_prev    <= 1'b1;
      r_armed         <= 1'b0;
      r_ringing       <= 1'b0;
      r_snooze_active <= 1'b0;
      r_buzzer        <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_alarm_hours   <= w_next_alarm_hours;
      r_alarm_minutes <= w_next_alarm_minutes;
      r_ring_cnt      <= w_next_ring_cnt;
      r_snooze_cnt    <= w_next_snooze_cnt;
      r_match_prev    <= w_next_match_prev;
      // Status flags decode the next state so they line up with it exactly.
      r_armed         <= (w_next_state != ST_DISARMED);
      r_ringing       <= (w_next_state == ST_RINGING);
      r_snooze_active <= (w_next_state == ST_SNOOZE);
      r_buzzer        <= (w_next_state == ST_RINGING) && !w_next_ring_cnt[0];
    end
  end

  assign o_alarm_hours   = r_alarm_hours;
  assign o_alarm_minutes = r_alarm_minutes;
  assign o_armed         = r_armed;
  assign o_ringing       = r_ringing;
  assign o_snooze_active = r_snooze_active;
  assign o_buzzer        = r_buzzer;

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Alarm scheduler for the 24-hour timekeeper.
- Holds an alarm time (hours/minutes) and compares it against the running time.
- Sequences disarmed/armed/ringing/snooze states and drives a gated buzzer enable.
- Sits beside the timekeeping datapath; consumes its hours/minutes/seconds and 1 Hz tick, and takes debounced one-cycle key pulses from the input stage.

Parameters:
SNOOZE_SECS, 300, snooze duration in 1 Hz ticks (1..4095)
RING_TIMEOUT_SECS, 600, ticks of continuous ringing before auto-stop (1..4095)

Ports:
CLOCK_24  input  1  system clock (24 MHz); all logic on posedge
RESET  input  1  synchronous, active-high reset
tick_1hz  input  1  one-cycle pulse once per second from timekeeper
hours  input  5  current hour, 0-23
minutes  input  6  current minute, 0-59
seconds  input  6  current second, 0-59
set_hour_inc  input  1  one-cycle pulse: alarm hour +1
set_minute_inc  input  1  one-cycle pulse: alarm minute +1
arm_toggle  input  1  one-cycle pulse: toggle armed/disarmed
snooze  input  1  one-cycle pulse: snooze a ringing alarm
dismiss  input  1  one-cycle pulse: stop ringing/snooze, stay armed
alarm_hours  output  5  stored alarm hour, 0-23
alarm_minutes  output  6  stored alarm minute, 0-59
armed  output  1  1 in every state except DISARMED
ringing  output  1  1 only in RINGING
snooze_active  output  1  1 only in SNOOZE
buzzer  output  1  buzzer enable, 1 s on / 1 s off pattern while RINGING

Behaviour:
- All outputs are registered. Any input event is visible on outputs in the cycle after it is sampled.
- RESET (sync, highest priority) sets the following:
  - state=DISARMED, alarm_hours=0, alarm_minutes=0.
  - ring_cnt=0, snooze_cnt=0, match_prev=1.
  - All 1-bit outputs 0.
- Reset asserted mid-ring or mid-snooze aborts immediately, with the same values.
- Match condition: hours==alarm_hours && minutes==alarm_minutes && seconds==0. Evaluated every cycle.
- match_prev registers the condition every cycle. A trigger is the rising edge: match && !match_prev.
- Alarm edits:
  - set_hour_inc wraps 23->0. set_minute_inc wraps 59->0. No carry from minute to hour.
  - Both may be applied in the same cycle.
  - Edits are accepted only in DISARMED and ARMED; they are ignored in RINGING and SNOOZE.
  - In any cycle with an accepted edit, match_prev is forced to 1, so an edit never directly triggers.
- FSM:
  - DISARMED: arm_toggle -> ARMED. Triggers are ignored.
  - ARMED:
    - arm_toggle -> DISARMED.
    - A trigger -> RINGING with ring_cnt=0.
    - arm_toggle wins over a simultaneous trigger.
  - RINGING:
    - ring_cnt increments on each tick_1hz.
    - buzzer = !ring_cnt[0], so it is high for the first second.
    - Event priority, highest first:
      1. arm_toggle -> DISARMED
      2. dismiss -> ARMED
      3. snooze -> SNOOZE, loading snooze_cnt=SNOOZE_SECS
      4. timeout -> ARMED
    - Timeout occurs when a tick arrives with ring_cnt==RING_TIMEOUT_SECS-1.
  - SNOOZE:
    - buzzer=0.
    - snooze_cnt decrements on each tick_1hz.
    - A tick arriving with snooze_cnt==1 -> RINGING, ring_cnt=0.
    - Priority: arm_toggle -> DISARMED, then dismiss -> ARMED, then the expiry.
    - snooze pulses are ignored.
- Leaving RINGING or SNOOZE forces buzzer=0 in the same registered update.
- Counter widths are 12 bits. No overflow is possible within the parameter limits.
- Triggers that arrive while in RINGING or SNOOZE are ignored. match_prev still tracks the condition.

Test Plan:
- Reset, arm_toggle, 6 x set_hour_inc, 30 x set_minute_inc; drive hours=6, minutes=30, seconds 59->0 -> alarm_hours=6, alarm_minutes=30, armed=1, then ringing=1 one cycle after seconds=0. buzzer=1 for ticks 0, off tick 1, on tick 2.
- In ARMED, hold time at 06:30:00, then press set_minute_inc 60 times back to 30 -> no ringing. Wrap checks: 59->0 and hour 23->0.
- While ringing, pulse snooze (SNOOZE_SECS=3 in bench) -> snooze_active=1, buzzer=0. After the 3rd tick, ringing=1 again with ring_cnt restarted.
- While ringing, apply arm_toggle and dismiss in the same cycle -> armed=0, ringing=0. Separately, dismiss alone -> armed=1, ringing=0, and no retrigger while seconds stays 0.
- With RING_TIMEOUT_SECS=4, ring without input -> ringing falls after the 4th tick and the state returns to ARMED. Raise RESET mid-ring -> all outputs 0 and the alarm time back to 00:00 next cycle.
